// File: rtl/parity_frame_checker.sv
//------------------------------------------------------------------------------
// Module   : parity_frame_checker
// Brief    : Re-checks XOR-stage parity taps per nibble; frame parity/error count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             frame_par,
    output logic [CNT_W-1:0] err_cnt,
    output logic [IDX_W-1:0] idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             frame_par_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [IDX_W-1:0] idx_q;

    logic [2:0]       w_exp_taps;
    logic             w_mismatch;
    logic             w_nib_par;
    logic [CNT_W-1:0] err_cnt_d;

    assign w_nib_par  = a ^ b ^ c ^ d;
    assign w_exp_taps = {a ^ b, a ^ b ^ c, w_nib_par};
    assign w_mismatch = ({e, f, g} != w_exp_taps);
    // Counter saturates at all-ones so a badly broken stage never reads as clean
    assign err_cnt_d  = (w_mismatch && (err_cnt_q != C_CNT_MAX))
                      ? err_cnt_q + CNT_W'(1) : err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_par_q <= 1'b0;
            err_cnt_q   <= '0;
            idx_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        frame_par_q <= 1'b0;
                        err_cnt_q   <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (valid) begin
                        frame_par_q <= frame_par_q ^ w_nib_par;
                        err_q       <= w_mismatch;
                        err_cnt_q   <= err_cnt_d;
                        idx_q       <= idx_q + IDX_W'(1);
                        if (idx_q == C_IDX_LAST) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign frame_par = frame_par_q;
    assign err_cnt   = err_cnt_q;
    assign idx       = idx_q;

endmodule

`default_nettype wire
